// File: rtl/sdram_rw_sched.sv
// Write/read burst scheduler that runs a circular SDRAM region between two user FIFOs and sdram_ctrl.
// Optional SDRAM_SCHED_LEVEL_CHECK_EN: track buffered words and block underrun/overrun.
module sdram_rw_sched #(
  parameter int          BURST_LEN    = 256,
  parameter logic [23:0] ADDR_BASE    = 24'h000000,
  parameter int          REGION_WORDS = 4096,
  parameter int          FIFO_DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [10:0] wr_fifo_cnt,
  input  logic [10:0] rd_fifo_cnt,
  input  logic        wr_ack,
  input  logic        rd_ack,
  output logic        wr_req,
  output logic [23:0] wr_addr,
  output logic [9:0]  wr_burst_len,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic [9:0]  rd_burst_len,
  output logic        busy,
  output logic [24:0] level
);

  localparam logic [23:0] BL24     = 24'(BURST_LEN);
  localparam logic [23:0] ADDR_END = ADDR_BASE + 24'(REGION_WORDS);
  localparam logic [10:0] BL11     = 11'(BURST_LEN);
  localparam logic [10:0] RD_ROOM  = 11'(FIFO_DEPTH - BURST_LEN);
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
  localparam logic [24:0] BL25     = 25'(BURST_LEN);
  localparam logic [24:0] LVL_MAX  = 25'(REGION_WORDS - BURST_LEN);
`endif

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;

  state_t      state;
  logic        wr_ack_q, rd_ack_q;
  logic        last_wr;
  logic        clr_pend;
  logic        we, re;
  logic [23:0] wr_next, rd_next;

  assign wr_burst_len = 10'(BURST_LEN);
  assign rd_burst_len = 10'(BURST_LEN);

  always_comb begin
    we = (wr_fifo_cnt >= BL11);
    re = (rd_fifo_cnt <= RD_ROOM);
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
    we = we && (level <= LVL_MAX);
    re = re && (level >= BL25);
`endif
    wr_next = (wr_addr + BL24 == ADDR_END) ? ADDR_BASE : wr_addr + BL24;
    rd_next = (rd_addr + BL24 == ADDR_END) ? ADDR_BASE : rd_addr + BL24;
  end

`ifndef SDRAM_SCHED_LEVEL_CHECK_EN
  assign level = '0;
`endif

  // The address outputs double as the burst pointers; they only move on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_req   <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
      wr_addr  <= ADDR_BASE;
      rd_addr  <= ADDR_BASE;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      last_wr  <= 1'b0;
      clr_pend <= 1'b0;
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
      level    <= '0;
`endif
    end else begin
      wr_ack_q <= wr_ack;
      rd_ack_q <= rd_ack;
      if (clr && state != IDLE) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clr) begin
            wr_addr  <= ADDR_BASE;
            rd_addr  <= ADDR_BASE;
            clr_pend <= 1'b0;
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
            level    <= '0;
`endif
          end else if (we && !(re && last_wr)) begin
            state  <= WR_REQ;
            wr_req <= 1'b1;
            busy   <= 1'b1;
          end else if (re) begin
            state  <= RD_REQ;
            rd_req <= 1'b1;
            busy   <= 1'b1;
          end
        end
        WR_REQ: begin
          if (wr_ack) begin
            state  <= WR_BURST;
            wr_req <= 1'b0;
          end
        end
        WR_BURST: begin
          if (wr_ack_q && !wr_ack) begin
            state    <= IDLE;
            busy     <= 1'b0;
            last_wr  <= 1'b1;
            clr_pend <= 1'b0;
            // A clear arriving with or before completion takes precedence over the pointer step.
            if (clr || clr_pend) begin
              wr_addr <= ADDR_BASE;
              rd_addr <= ADDR_BASE;
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
              level   <= '0;
`endif
            end else begin
              wr_addr <= wr_next;
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
              level   <= level + BL25;
`endif
            end
          end
        end
        RD_REQ: begin
          if (rd_ack) begin
            state  <= RD_BURST;
            rd_req <= 1'b0;
          end
        end
        RD_BURST: begin
          if (rd_ack_q && !rd_ack) begin
            state    <= IDLE;
            busy     <= 1'b0;
            last_wr  <= 1'b0;
            clr_pend <= 1'b0;
            if (clr || clr_pend) begin
              wr_addr <= ADDR_BASE;
              rd_addr <= ADDR_BASE;
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
              level   <= '0;
`endif
            end else begin
              rd_addr <= rd_next;
`ifdef SDRAM_SCHED_LEVEL_CHECK_EN
              level   <= level - BL25;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_rw_sched.md
# sdram_rw_sched

Burst scheduler between two user-side FIFOs (write-in, read-out) and `sdram_ctrl`. Decides when to issue a write burst (write FIFO holds a full burst) or a read burst (read FIFO has room for a full burst), and generates `wr_req`/`rd_req` with wrapping addresses and a fixed burst length. Alternates fairly between directions, tracks burst completion from `wr_ack`/`rd_ack`, and treats a region of SDRAM as a circular buffer.

## Interface
- `BURST_LEN`, 256: words per burst; 1..512, must not cross a 512-column row.
- `ADDR_BASE`, 24'h000000: first word address of the buffer region; BURST_LEN-aligned.
- `REGION_WORDS`, 4096: region size in words; multiple of BURST_LEN.
- `FIFO_DEPTH`, 1024: read-out FIFO depth in words; ≥ BURST_LEN.

Ports:
- `clk` in 1: system clock, same as `sdram_ctrl`.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: single-cycle pulse that clears pointers and level.
- `wr_fifo_cnt` in 11: words currently in the write-in FIFO.
- `rd_fifo_cnt` in 11: words currently in the read-out FIFO.
- `wr_ack` in 1: from `sdram_ctrl`; high for each accepted write word.
- `rd_ack` in 1: from `sdram_ctrl`; high for each valid read word.
- `wr_req` out 1: write burst request to `sdram_ctrl`.
- `wr_addr` out 24: write burst start address.
- `wr_burst_len` out 10: constant BURST_LEN.
- `rd_req` out 1: read burst request.
- `rd_addr` out 24: read burst start address.
- `rd_burst_len` out 10: constant BURST_LEN.
- `busy` out 1: high in any state except IDLE.
- `level` out 25: words buffered in SDRAM (written but not yet read).

## Operation
- State machine states: IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST.
- Write eligibility `we`: `wr_fifo_cnt >= BURST_LEN`.
- Read eligibility `re`: `rd_fifo_cnt <= FIFO_DEPTH - BURST_LEN`.
- IDLE:
  - Only `we` true → WR_REQ.
  - Only `re` true → RD_REQ.
  - Both true → the direction opposite to `last_grant`. `last_grant` resets to read, so the first contested grant goes to write.
  - Neither true → stay in IDLE.
- WR_REQ:
  - `wr_req`=1 and `wr_addr`=`wr_ptr`, both held until the first `wr_ack`=1.
  - In that cycle → WR_BURST; `wr_req` drops the following cycle.
- WR_BURST:
  - Wait for a falling edge of `wr_ack` (registered ack =1, current ack =0).
  - On that edge: `wr_ptr += BURST_LEN`, wrapping to ADDR_BASE at ADDR_BASE+REGION_WORDS; set `last_grant`=write; → IDLE.
- RD_REQ and RD_BURST: identical to the write path, using `rd_req`, `rd_ack`, `rd_ptr`.
- Pointer arithmetic is done on 24 bits relative to ADDR_BASE. The wrap compare uses `ptr + BURST_LEN == ADDR_BASE + REGION_WORDS`.
- `clr`:
  - In IDLE: takes effect immediately.
  - Otherwise: latched as pending and applied on the transition back to IDLE; the current burst is never aborted.
  - Effect: `wr_ptr` = `rd_ptr` = ADDR_BASE, `level` = 0.
- Simultaneous `clr` and burst completion: `clr` wins, so pointers end at ADDR_BASE.

## Timing
- Reset values:
  - `wr_req`=`rd_req`=0, `busy`=0, `level`=0, state IDLE.
  - `wr_addr`=`rd_addr`=ADDR_BASE.
  - `wr_burst_len`=`rd_burst_len`=BURST_LEN (constant).
- All outputs are registered.
- Request latency: `wr_req`/`rd_req` rises 1 cycle after IDLE evaluates eligible.
- Request deassert: 1 cycle after the first ack is sampled high.
- Completion: the next IDLE decision happens 1 cycle after the ack falling edge. Minimum gap from the end of one burst's acks to the next request is 2 cycles.
- Only one of `wr_req`/`rd_req` is ever high; they are never high in the same cycle.
- Addresses are stable for the whole time the request is high.
- `rst` mid-burst clears everything asynchronously. `sdram_ctrl` shares this reset, so no recovery handshake is needed.

## Configuration
- Macro `SDRAM_SCHED_LEVEL_CHECK_EN`.
- Defined:
  - `level` is kept up to date: +BURST_LEN on write completion, −BURST_LEN on read completion.
  - `re` additionally requires `level >= BURST_LEN`.
  - `we` additionally requires `level <= REGION_WORDS - BURST_LEN`.
  - Result: no underrun (reading unwritten data) and no overrun (overwriting unread data).
- Undefined:
  - `level` is tied to 0.
  - Reads and writes are gated only by FIFO counts; `rd_ptr` runs independently of `wr_ptr` (free-running frame-buffer use).

## Test plan
- Reset, with `wr_fifo_cnt`=0 and `rd_fifo_cnt`=1024 → no request; all addresses 0; `busy`=0. With the macro defined, no read is issued because `level`=0.
- `wr_fifo_cnt`=256, `rd_fifo_cnt`=1024, 256 `wr_ack` pulses modelled → exactly one write with `wr_addr`=0 and `wr_burst_len`=256; after completion `wr_ptr`=256 and `level`=256 (macro).
- Both eligible continuously with `level`≥256 → grants alternate W,R,W,R; `wr_req` and `rd_req` are never high together.
- 16 consecutive writes with REGION_WORDS=4096, macro undefined → addresses 0,256,…,3840, then 0 again.
- Macro defined, `level`=4096 → `we` blocked even with `wr_fifo_cnt`=1000; after one read, `level`=3840 and the write is issued.
- `clr` pulse during WR_BURST → burst completes normally; then `wr_ptr`=`rd_ptr`=0 and `level`=0 in IDLE.
